alu_4bit: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_comb.sv | 66 ++++++
 rtl/alu_4bit.sv | 70 +++++++
 tb/tb_alu_4bit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU: default operand width, the
// opcode type and the named opcode encodings used by alu_comb and alu_4bit.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_XOR = 3'b100;
    localparam alu_op_t ALU_NOR = 3'b101;
    localparam alu_op_t ALU_SHL = 3'b110;
    localparam alu_op_t ALU_SHR = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// ---------------------------------------------------------------------------
// alu_comb
// Purely combinational ALU core. Produces the next result and the
// carry / borrow / shifted-out bit from the two operands and the opcode.
//
// Ports:
//   a_i      in   WIDTH  operand A (unsigned)
//   b_i      in   WIDTH  operand B (unsigned), unused by the shift ops
//   op_i     in   3      opcode (alu_op_t)
//   result_o out  WIDTH  next result
//   carry_o  out  1      next carry / borrow / shifted-out bit
// ---------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    // One extra bit on both arithmetic paths: for ADD it is the carry, for
    // SUB the zero-extended difference wraps, so the top bit is the borrow
    // (set exactly when a < b).
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum_w[WIDTH-1:0];
                carry_o  = sum_w[WIDTH];
            end
            ALU_SUB: begin
                result_o = diff_w[WIDTH-1:0];
                carry_o  = diff_w[WIDTH];
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SHL: begin
                result_o = {a_i[WIDTH-2:0], 1'b0};
                carry_o  = a_i[WIDTH-1];
            end
            ALU_SHR: begin
                result_o = {1'b0, a_i[WIDTH-1:1]};
                carry_o  = a_i[0];
            end
            // Only reachable with X/Z on the opcode; park on a zero result.
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule : alu_comb

// File: rtl/alu_4bit.sv
// ---------------------------------------------------------------------------
// alu_4bit
// Registered ALU. Inputs are sampled on every rising clk edge and the
// result and flags appear one cycle later, driven straight from flops.
// No handshake; the block accepts a new operation every cycle.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   a          in   WIDTH  operand A (unsigned)
//   b          in   WIDTH  operand B (unsigned), unused by the shift ops
//   alu_op     in   3      opcode
//   result     out  WIDTH  registered result
//   carry_out  out  1      registered carry / borrow / shifted-out bit
//   zero       out  1      registered flag, 1 when result == 0
// ---------------------------------------------------------------------------
module alu_4bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alu_op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_d;
    logic             carry_q;
    logic             zero_d;
    logic             zero_q;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a_i      (a),
        .b_i      (b),
        .op_i     (alu_op),
        .result_o (result_d),
        .carry_o  (carry_d)
    );

    // Zero is computed from the next result and registered alongside it, so
    // the flag never lags or leads the result it describes.
    assign zero_d = (result_d == '0);

    // Reset value keeps zero consistent with a cleared result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;

endmodule : alu_4bit

// File: tb/tb_alu_4bit.sv
module tb_alu_4bit;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_op;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    int n_tests;
    int n_fail;
    bit check_en;

    // Expected registered outputs, tracked by the bench's own model.
    int exp_res;
    int exp_c;

    alu_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Returns carry*M + result.
    function automatic int model(input int av, input int bv, input int op);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0: begin r = av + bv;            c = (av + bv >= M) ? 1 : 0; end
            1: begin r = av - bv + M;        c = (av < bv) ? 1 : 0;      end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = (M - 1) - (av | bv);
            6: begin r = av * 2;             c = (av >= M / 2) ? 1 : 0;  end
            default: begin r = av / 2;       c = av % 2;                 end
        endcase
        return c * M + (r % M);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_res <= 0;
            exp_c   <= 0;
        end else begin
            exp_res <= model(int'(a), int'(b), int'(alu_op)) % M;
            exp_c   <= model(int'(a), int'(b), int'(alu_op)) / M;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            n_tests++;
            if (int'(result) != exp_res || int'(carry_out) != exp_c ||
                zero != (exp_res == 0)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got res=%b c=%b z=%b, expected res=%0d c=%0d z=%0d",
                         $time, result, carry_out, zero, exp_res, exp_c, (exp_res == 0));
            end
            n_tests++;
            if (zero != (result == '0)) begin
                n_fail++;
                $display("FAIL zero_invariant t=%0t: got z=%b for res=%b", $time, zero, result);
            end
        end
    end

    task automatic check_now(input string name, input logic [W-1:0] er,
                             input logic ec, input logic ez);
        n_tests++;
        if (result !== er || carry_out !== ec || zero !== ez) begin
            n_fail++;
            $display("FAIL %s: got res=%b c=%b z=%b, expected res=%b c=%b z=%b",
                     name, result, carry_out, zero, er, ec, ez);
        end
    endtask

    // Drive one vector after an edge, then check the registered outputs
    // just after the edge that captures it.
    task automatic run(input string name, input logic [2:0] op,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic ec, input logic ez);
        @(posedge clk);
        #2;
        alu_op = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        check_now(name, er, ec, ez);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        check_en = 1'b0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        alu_op   = 3'b000;

        #1;
        check_now("reset_initial", 4'b0000, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check_en = 1'b1;

        // Arithmetic
        run("add_3_1",    3'b000, 4'b0011, 4'b0001, 4'b0100, 1'b0, 1'b0);
        run("add_15_1",   3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
        run("sub_5_3",    3'b001, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);
        run("sub_3_5",    3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0);
        run("sub_7_7",    3'b001, 4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b1);
        // Logic
        run("and",        3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0);
        run("or",         3'b011, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0);
        run("xor",        3'b100, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0);
        run("nor",        3'b101, 4'b1100, 4'b1010, 4'b0001, 1'b0, 1'b0);
        run("nor_ones",   3'b101, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1);
        // Shifts, b both all-ones and all-zeros
        run("shl_5_b0",   3'b110, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0);
        run("shl_5_b15",  3'b110, 4'b0101, 4'b1111, 4'b1010, 1'b0, 1'b0);
        run("shl_8_b0",   3'b110, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        run("shl_8_b15",  3'b110, 4'b1000, 4'b1111, 4'b0000, 1'b1, 1'b1);
        run("shr_5_b0",   3'b111, 4'b0101, 4'b0000, 4'b0010, 1'b1, 1'b0);
        run("shr_5_b15",  3'b111, 4'b0101, 4'b1111, 4'b0010, 1'b1, 1'b0);
        run("shr_1_b0",   3'b111, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
        run("shr_1_b15",  3'b111, 4'b0001, 4'b1111, 4'b0000, 1'b1, 1'b1);

        // Mid-stream async reset with result = 1010
        run("pre_reset",  3'b110, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_async", 4'b0000, 1'b0, 1'b1);
        a      = 4'b1111;
        b      = 4'b0001;
        alu_op = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold", 4'b0000, 1'b0, 1'b1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_now("reset_release", 4'b0000, 1'b1, 1'b1);

        // Back-to-back: every opcode, new operands each cycle
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            alu_op = 3'(i);
            a      = 4'((i * 5 + 3) % M);
            b      = 4'((i * 3 + 7) % M);
        end
        @(posedge clk);
        #1;
        // last op SHR of a = (7*5+3)%16 = 6 -> 0011, c0
        check_now("pipe_last", 4'b0011, 1'b0, 1'b0);

        // Random vectors with occasional reset pulses
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            a      = 4'($urandom_range(0, M - 1));
            b      = 4'($urandom_range(0, M - 1));
            alu_op = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_4bit
